// File: rtl/mem_cfg_arbiter.sv
// Round-robin arbiter that shares the single mem/config bus among NUM_REQ requesters.
// It accepts one request at a time, drives one bus transaction per request and returns a one-hot completion pulse.
module mem_cfg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RD_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [2*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   mem_enable,
    output logic                   mem_write,
    output logic [1:0]             mem_address,
    output logic [7:0]             mem_data,
    input  logic [7:0]             mem_rdata,
    output logic                   busy
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] gsel;
    logic          cap_write;
    logic [2:0]    cnt;
    logic          gnt_vld;
    logic [GW-1:0] gnt_idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = GW'(idx);
            end
        end
    end

    assign req_ready = (state == IDLE && gnt_vld && !reset) ? onehot(gnt_idx) : '0;
    assign busy      = (state != IDLE);

    // Bus fields are registered on the handshake edge, so later payload changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gsel        <= '0;
            cap_write   <= 1'b0;
            cnt         <= '0;
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
        end else begin
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            rsp_valid   <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        gsel        <= gnt_idx;
                        cap_write   <= req_write[gnt_idx];
                        rr_ptr      <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        mem_enable  <= 1'b1;
                        mem_write   <= req_write[gnt_idx];
                        mem_address <= req_addr[2*int'(gnt_idx) +: 2];
                        mem_data    <= req_data[8*int'(gnt_idx) +: 8];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cap_write) begin
                        rsp_valid <= onehot(gsel);
                        rsp_data  <= '0;
                        state     <= RESP;
                    end else begin
                        cnt   <= 3'(RD_LAT);
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    cnt <= cnt - 3'd1;
                    // cnt==1 marks the cycle RD_LAT after the enable cycle.
                    if (cnt == 3'd1) begin
                        rsp_data  <= mem_rdata;
                        rsp_valid <= onehot(gsel);
                        state     <= RESP;
                    end
                end
                default: begin
                    rsp_data <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cfg_arbiter.sv
// Directed bench for mem_cfg_arbiter (NUM_REQ=4, RD_LAT=2) with hand-computed expectations.
module tb_mem_cfg_arbiter;
    localparam int N  = 4;
    localparam int RL = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_write = '0;
    logic [2*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           mem_enable;
    logic           mem_write;
    logic [1:0]     mem_address;
    logic [7:0]     mem_data;
    logic [7:0]     mem_rdata = '0;
    logic           busy;

    int n_chk  = 0;
    int n_pass = 0;

    mem_cfg_arbiter #(.NUM_REQ(N), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data(mem_data), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic wr, input logic [1:0] a, input logic [7:0] d);
        req_write[i]       = wr;
        req_addr[2*i +: 2] = a;
        req_data[8*i +: 8] = d;
    endtask

    // Advance to the next negedge and let combinational outputs settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g_seen[$];
        int exp_g[6];
        int ens, viol, rsp_or, en_cyc[$];
        exp_g = '{0, 1, 2, 3, 0, 1};

        // Reset with all requesters valid: outputs must stay at zero.
        req_valid = 4'hF;
        req_write = 4'hF;
        tick(); tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_men", 32'(mem_enable), 0);
        check("rst_rsp", 32'(rsp_valid), 0);

        // All four continuously valid from reset: round-robin 0,1,2,3,0,1.
        @(negedge clk);
        reset = 1'b0;
        ens = 0; viol = 0;
        for (int c = 0; c < 40 && g_seen.size() < 6; c++) begin
            #1;
            if (mem_enable) ens++;
            if (req_ready != 0 && busy) viol++;
            if (req_ready != 0) g_seen.push_back(idx_of(req_ready));
            @(negedge clk);
        end
        #1;
        if (mem_enable) ens++;
        req_valid = '0;
        check("rr_count", 32'(g_seen.size()), 6);
        for (int k = 0; k < 6; k++)
            if (k < g_seen.size()) check($sformatf("rr_order%0d", k), 32'(g_seen[k]), 32'(exp_g[k]));
        check("rr_enables", 32'(ens), 6);
        check("rr_busy_grant", 32'(viol), 0);
        tick(); tick(); tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Write from req 0, addr 1, data A5; payload scrambled after handshake.
        set_lane(0, 1'b1, 2'd1, 8'hA5);
        req_valid = 4'b0001;
        #1;
        check("w_ready", 32'(req_ready), 32'b0001);
        check("w_en_before", 32'(mem_enable), 0);
        tick();
        req_valid = '0;
        set_lane(0, 1'b0, 2'd2, 8'h5A);
        #1;
        check("w_en", 32'(mem_enable), 1);
        check("w_wr", 32'(mem_write), 1);
        check("w_addr", 32'(mem_address), 1);
        check("w_data", 32'(mem_data), 32'hA5);
        check("w_busy", 32'(busy), 1);
        check("w_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("w_en_after", 32'(mem_enable), 0);
        check("w_data_after", 32'(mem_data), 0);
        check("w_rsp", 32'(rsp_valid), 32'b0001);
        check("w_rsp_data", 32'(rsp_data), 0);
        tick();
        check("w_rsp_end", 32'(rsp_valid), 0);
        check("w_idle", 32'(busy), 0);

        // Read from req 2 (rr_ptr=1), addr 3; only the E+2 value is captured.
        set_lane(2, 1'b0, 2'd3, 8'h77);
        req_valid = 4'b0100;
        #1;
        check("r_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        check("r_en", 32'(mem_enable), 1);
        check("r_wr", 32'(mem_write), 0);
        check("r_addr", 32'(mem_address), 3);
        check("r_data", 32'(mem_data), 32'h77);
        mem_rdata = 8'h11;
        tick();
        check("r_rsp_e1", 32'(rsp_valid), 0);
        check("r_en_e1", 32'(mem_enable), 0);
        check("r_busy_e1", 32'(busy), 1);
        mem_rdata = 8'hEE;
        tick();
        check("r_rsp_e2", 32'(rsp_valid), 0);
        mem_rdata = 8'h3C;
        tick();
        mem_rdata = 8'h00;
        check("r_rsp", 32'(rsp_valid), 32'b0100);
        check("r_rsp_data", 32'(rsp_data), 32'h3C);
        tick();
        check("r_rsp_data_clr", 32'(rsp_data), 0);
        check("r_idle", 32'(busy), 0);

        // Req 1 write (rr_ptr=3 scans 3,0,1) leaves rr_ptr=2.
        set_lane(1, 1'b1, 2'd0, 8'h01);
        req_valid = 4'b0010;
        #1;
        check("p_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        check("p_rsp", 32'(rsp_valid), 32'b0010);
        tick();

        // Requesters 3 and 1 with rr_ptr=2: 3 first, then wrap to 0 and serve 1.
        set_lane(3, 1'b1, 2'd2, 8'h33);
        set_lane(1, 1'b1, 2'd1, 8'h11);
        req_valid = 4'b1010;
        #1;
        check("wrap_first", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0010;
        #1;
        check("wrap_en", 32'(mem_enable), 1);
        check("wrap_no_ready_busy", 32'(req_ready), 0);
        tick();
        check("wrap_rsp3", 32'(rsp_valid), 32'b1000);
        tick();
        check("wrap_second", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick(); tick(); tick();

        // Reset during WAIT_RD of a read from req 1 aborts it.
        set_lane(1, 1'b0, 2'd2, 8'h00);
        req_valid = 4'b0010;
        #1;
        check("ab_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        #1;
        check("ab_en", 32'(mem_enable), 1);
        mem_rdata = 8'h99;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ab_busy", 32'(busy), 0);
        check("ab_en_clr", 32'(mem_enable), 0);
        check("ab_rsp", 32'(rsp_valid), 0);
        check("ab_rsp_data", 32'(rsp_data), 0);
        rsp_or = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            rsp_or = rsp_or | int'(rsp_valid);
        end
        check("ab_no_rsp", 32'(rsp_or), 0);
        set_lane(0, 1'b1, 2'd0, 8'h42);
        set_lane(3, 1'b1, 2'd0, 8'h24);
        req_valid = 4'b1001;
        #1;
        check("ab_rr_reset", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        #1;
        check("ab_w_data", 32'(mem_data), 32'h42);
        tick();
        check("ab_w_rsp", 32'(rsp_valid), 32'b0001);
        tick(); tick();

        // Back-to-back writes from req 0: enables 3 cycles apart, ready only in IDLE.
        set_lane(0, 1'b1, 2'd3, 8'hC3);
        req_valid = 4'b0001;
        viol = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (mem_enable) en_cyc.push_back(c);
            if (req_ready != 0 && busy) viol++;
            if (req_ready == 0 && !busy) viol++;
            @(negedge clk);
        end
        req_valid = '0;
        check("b2b_count", 32'(en_cyc.size() >= 3), 1);
        for (int k = 1; k < en_cyc.size(); k++)
            check($sformatf("b2b_gap%0d", k), 32'(en_cyc[k] - en_cyc[k-1]), 3);
        check("b2b_ready_idle", 32'(viol), 0);
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_cfg_arbiter.md
Name: mem_cfg_arbiter

Overview:
Round-robin arbiter and sequencer that shares the switch's single memory/configuration bus (enable, write, 2-bit address, 8-bit data) among NUM_REQ requesters, for example the host-config agent, the port-table loader and the debug reader. It accepts one request at a time with a valid/ready handshake and drives exactly one bus transaction per request. It returns a per-requester completion pulse, carrying read data for reads. It sits between the requesters and the config-register block, which presents the mem bus interface.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
RD_LAT, 2, cycles from the mem_enable cycle to valid mem_rdata; legal range 1..7.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_write  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
req_addr  input  2*NUM_REQ  per-requester address; requester i uses bits [2i+1:2i].
req_data  input  8*NUM_REQ  per-requester write data; requester i uses bits [8i+7:8i].
req_ready  output  NUM_REQ  one-hot accept; the transfer happens on the edge where valid[i] and ready[i] are both high.
rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse.
rsp_data  output  8  read data, valid with rsp_valid; 0 for writes.
mem_enable  output  1  bus transaction strobe.
mem_write  output  1  bus op.
mem_address  output  2  bus address.
mem_data  output  8  bus write data.
mem_rdata  input  8  bus read data.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, checked before any other logic:
  - state <= IDLE, rr_ptr <= 0, latency counter <= 0.
  - All outputs are 0: req_ready, rsp_valid, rsp_data, mem_*, busy.
  - Reset asserted mid-transaction aborts it: no rsp_valid, and the bus returns to idle on the next cycle.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first i with req_valid[i] high, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is all-zero when no valid is high, and in every state other than IDLE.
  - On handshake with index g: capture g, req_write[g], req_addr[g], req_data[g]; rr_ptr <= (g+1) mod NUM_REQ; state goes to ISSUE.
- ISSUE (exactly one cycle, cycle E):
  - mem_enable=1 and mem_write/mem_address/mem_data come from the captured fields.
  - A write goes to RESP. A read loads the counter with RD_LAT and goes to WAIT_RD.
- Outside ISSUE, mem_enable, mem_write, mem_address and mem_data are all 0 (registered outputs, no glitches).
- WAIT_RD:
  - The counter decrements each cycle.
  - On the edge closing cycle E+RD_LAT, capture mem_rdata into rsp_data and go to RESP.
  - With RD_LAT=1, WAIT_RD lasts one cycle.
- RESP (one cycle):
  - rsp_valid[g]=1 and rsp_data holds the captured read data, or 0 for a write.
  - Next state is IDLE. rsp_data returns to 0 afterwards.
- Latency, measuring from handshake edge T:
  - Write: enable in cycle T+1, rsp_valid in T+2, next grant possible in T+3.
  - Read: enable in T+1, rsp_valid in T+2+RD_LAT.
- Fairness: after requester g is served, every other asserted requester is served before g again. rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous requests: the arbiter services only the granted requester. Others must hold valid and payload stable until their ready; ungranted requests are never dropped.
- If a requester deasserts req_valid while ungranted, no transfer occurs. This is tolerated and state is unaffected.
- Payload changes after the handshake do not affect the transaction in flight.
- busy = (state != IDLE).

Test Plan:
- Reset, then write from req 0 (addr 2'd1, data 8'hA5): mem_enable=1, write=1, address=1, data=A5 for exactly one cycle; rsp_valid=4'b0001 one cycle later with rsp_data=0. All bus outputs are 0 before and after.
- Read from req 2, RD_LAT=2, addr 2'd3, mem_rdata=8'h3C presented in cycle E+2: rsp_valid=4'b0100 in cycle E+3 with rsp_data=3C. A value driven in E+1 is not sampled.
- All four requesters valid continuously from reset: grant order is 0,1,2,3,0,1. Exactly one enable per grant, and no grant while busy=1.
- Requesters 3 and 1 valid with rr_ptr=2: req 3 is served first, then rr_ptr wraps to 0 and req 1 is served next.
- Reset asserted during WAIT_RD of a read from req 1: no rsp_valid ever for that read. The next cycle has all outputs 0 and rr_ptr=0; a following req 0 write completes normally.
- Back-to-back writes from req 0 alone: enable pulses are spaced exactly 3 cycles apart, and req_ready is high only in IDLE cycles.
